// File: rtl/pattern_gen_arbiter.sv
// Round-robin arbiter that time-shares one external 3-bit pattern generator among NREQ requesters:
// flushes the generator after reset, grants one requester per burst, pulses the go input, routes y back.
module pattern_gen_arbiter #(
  parameter int NREQ      = 4,
  parameter int BURST_CYC = 6,
  parameter int FLUSH_CYC = 5,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  output logic [NREQ-1:0]  gnt,
  output logic             fsm_x,
  input  logic             fsm_y,
  output logic [NREQ-1:0]  y_out,
  output logic             ready,
  output logic             busy,
  output logic [CNT_W-1:0] burst_cnt
);

  localparam int IDX_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TMR_MAX = (BURST_CYC > FLUSH_CYC) ? BURST_CYC : FLUSH_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  typedef enum logic [1:0] {
    ST_FLUSH,
    ST_IDLE,
    ST_FIRE,
    ST_RUN
  } state_t;

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [NREQ-1:0]    gnt_q, gnt_d;
  logic               x_q, x_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [NREQ-1:0]    win_vec;
  logic [IDX_W-1:0]   cand_idx;
  int                 cand;

  // Round-robin search: first asserted request strictly after the last grant, wrapping modulo NREQ.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path leaves a value held (no latch).
    win_found = 1'b0;
    win_idx   = last_q;
    win_vec   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int off = 1; off <= NREQ; off++) begin
      cand = int'(last_q) + off;
      if (cand >= NREQ) cand = cand - NREQ;
      cand_idx = IDX_W'(cand);
      if (!win_found && req[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
    win_vec[win_idx] = win_found;
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    gnt_d   = gnt_q;
    x_d     = 1'b0;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_FLUSH: begin
        if (tmr_q == TMR_W'(FLUSH_CYC - 1)) begin
          state_d = ST_IDLE;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      ST_IDLE: begin
        gnt_d = '0;
        if (win_found) begin
          state_d = ST_FIRE;
          gnt_d   = win_vec;
          x_d     = 1'b1;
          last_d  = win_idx;
        end
      end
      ST_FIRE: begin
        state_d = ST_RUN;
        tmr_d   = '0;
        cnt_d   = cnt_q + 1'b1;
      end
      ST_RUN: begin
        // RUN covers the remaining BURST_CYC-1 cycles; the generator is back at 000 on the next cycle.
        if (tmr_q == TMR_W'(BURST_CYC - 2)) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: state_d = ST_FLUSH;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_FLUSH;
      tmr_q   <= '0;
      gnt_q   <= '0;
      x_q     <= 1'b0;
      last_q  <= IDX_W'(NREQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      gnt_q   <= gnt_d;
      x_q     <= x_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign fsm_x     = x_q;
  assign burst_cnt = cnt_q;
  assign y_out     = gnt_q & {NREQ{fsm_y}};
  assign ready     = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_FIRE) || (state_q == ST_RUN);

endmodule

// File: doc/pattern_gen_arbiter.md
Name: pattern_gen_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 3-bit pattern-generator FSM (go input `x`, Mealy output `y`, no reset) among NREQ requesters.
- Datapath behaviour:
  - In idle state 000, `x`=1 starts a fixed 6-cycle sequence.
  - `y` over that sequence is 1,0,0,1,0,1.
  - With `x`=0, any state returns to 000 within 5 cycles.
- The block flushes the generator after reset, grants one requester per burst, pulses `x`, and routes `y` back to the granted requester.

Parameters:
- NREQ, 4, number of requesters (2..8).
- BURST_CYC, 6, cycles gnt is held per burst, counted from the fire cycle to the last cycle; the generator is in state 000 on the cycle after.
- FLUSH_CYC, 5, cycles fsm_x is held 0 after reset to force the generator to state 000.
- CNT_W, 8, width of the burst counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active-low
- req  input  NREQ  per-requester burst request, level
- gnt  output  NREQ  one-hot grant, registered, held for the whole burst
- fsm_x  output  1  go input to the generator, registered
- fsm_y  input  1  generator output
- y_out  output  NREQ  y_out[i] = fsm_y & gnt[i], combinational
- ready  output  1  high in IDLE
- busy  output  1  high in FIRE or RUN
- burst_cnt  output  CNT_W  number of bursts fired, wraps

Behaviour:
- Clock and reset:
  - One clock, clk.
  - rst_n is synchronous and active-low: sampled low at a rising edge, it takes effect at that edge.
- Reset values:
  - State is FLUSH and the flush counter is 0.
  - gnt=0, fsm_x=0, busy=0, ready=0, burst_cnt=0, so y_out=0.
  - The round-robin pointer is set so req[0] has top priority.
- FLUSH:
  - fsm_x=0 for FLUSH_CYC cycles, then go to IDLE.
  - req is ignored.
- IDLE:
  - ready=1.
  - If req != 0 at an edge, the round-robin winner is registered into gnt, fsm_x<=1, and the state goes to FIRE.
  - Otherwise stay in IDLE.
- Round-robin rule:
  - Search starts at last_granted+1 and wraps modulo NREQ.
  - last_granted updates on entry to FIRE.
- FIRE (1 cycle):
  - gnt is one-hot, fsm_x=1, busy=1.
  - burst_cnt increments on leaving FIRE, wrapping from 2^CNT_W-1 to 0.
- RUN:
  - fsm_x=0 and gnt is held.
  - Lasts BURST_CYC-1 cycles, then IDLE with gnt<=0.
- Latency:
  - A req seen in IDLE at edge t gives gnt and fsm_x=1 in cycle t+1.
  - gnt stays high through cycle t+BURST_CYC; ready=1 at t+BURST_CYC+1.
  - A continuously requesting sole requester gets one burst every BURST_CYC+1 cycles.
- Non-preemptive:
  - req changes during FIRE/RUN are ignored; a dropped req does not shorten the burst.
  - req is sampled only in IDLE.
- Simultaneous requests: exactly one gnt bit per burst, never two. Losers remain pending and are served in rotation order.
- Reset mid-burst:
  - At the edge where rst_n is low, gnt, fsm_x and busy clear.
  - The state goes to FLUSH with a full FLUSH_CYC count.
  - No partial burst resumes.
- y_out is 0 for every non-granted requester at all times, and 0 for all requesters outside FIRE/RUN.
- ready and busy are never both 1. Both are 0 only in FLUSH.

Test Plan:
- Reset, then FLUSH_CYC=5: after rst_n high, ready stays 0 for exactly 5 cycles with fsm_x=0, then ready=1. In all 5 cycles gnt=0000 and burst_cnt=0.
- Single request:
  - Stimulus: req=0100 held in IDLE.
  - gnt=0100 for 6 cycles, fsm_x=1 only in the first, y_out[2]=1,0,0,1,0,1, other bits 0.
  - burst_cnt=1; the next burst starts 7 cycles after the previous FIRE.
- All request:
  - Stimulus: req=1111 held after flush.
  - Grant order is 0001, 0010, 0100, 1000, 0001, with no gap longer than 1 IDLE cycle between bursts.
  - burst_cnt=5 after the fifth FIRE.
- Request drop mid-burst: req=0001 for one cycle only -> full 6-cycle burst still completes and ready returns, with no second burst.
- Reset mid-burst: rst_n low during RUN cycle 3 -> next cycle gnt=0, fsm_x=0, busy=0, ready=0; a fresh 5-cycle FLUSH follows and burst_cnt=0.
- Counter wrap with CNT_W=2: 5 back-to-back bursts -> burst_cnt sequence 1,2,3,0,1.
